// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-requester round-robin arbiter issuing SPI flash 0x03 word reads
module spi_flash_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, RESP} state_t;

  localparam logic [3:0] PH_LAST = 4'(CLK_DIV - 1);

  state_t      state_q;
  logic        last_q;
  logic        sclk_q;
  logic        csb_q;
  logic        mosi_q;
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [3:0]  phase_q;
  logic [5:0]  bit_q;
  logic [62:0] tx_q;
  logic [31:0] rx_q;
  logic [31:0] rsp0_data_q;
  logic [31:0] rsp1_data_q;

  logic        accept;
  logic        grant_d;
  logic [23:0] addr_d;
  logic [63:0] tx_d;
  logic        phase_last;
  logic [31:0] rx_swapped;

  always_comb begin
    accept  = (state_q == IDLE) && (req0_valid || req1_valid);
    grant_d = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    addr_d  = grant_d ? req1_addr : req0_addr;
    tx_d    = {8'h03, addr_d & 24'hFF_FFFC, 32'h0};
  end

  assign phase_last = (phase_q == PH_LAST);
  // Bytes arrive MSB first; the first byte on the wire lands in the low byte.
  assign rx_swapped = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

  assign req0_ready = resetb && accept && !grant_d;
  assign req1_ready = resetb && accept && grant_d;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign spi_csb    = csb_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign busy       = (state_q != IDLE);

  // last_q doubles as the grant of the transaction in flight.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      sclk_q       <= 1'b0;
      csb_q        <= 1'b1;
      mosi_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      phase_q      <= '0;
      bit_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_q  <= grant_d;
            tx_q    <= tx_d[62:0];
            mosi_q  <= tx_d[63];
            csb_q   <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
            state_q <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (phase_last) begin
            phase_q <= '0;
            state_q <= SHIFT;
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        SHIFT: begin
          if (!phase_last) begin
            phase_q <= phase_q + 4'd1;
          end else begin
            phase_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[30:0], spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 6'd63) begin
                csb_q   <= 1'b1;
                mosi_q  <= 1'b0;
                state_q <= CS_HOLD;
              end else begin
                bit_q  <= bit_q + 6'd1;
                mosi_q <= tx_q[62];
                tx_q   <= {tx_q[61:0], 1'b0};
              end
            end
          end
        end
        CS_HOLD: begin
          if (phase_last) begin
            phase_q <= '0;
            state_q <= RESP;
            if (last_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_data_q  <= rx_swapped;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_data_q  <= rx_swapped;
            end
          end else begin
            phase_q <= phase_q + 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - scoreboard bench for spi_flash_arbiter at CLK_DIV 2 and 1
module tb_spi_flash_arbiter;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic [1:0] v0 = '0, v1 = '0, miso = '0;
  logic [1:0] r0, r1, rv0, rv1, csb, sclk, mosi, busy;
  logic [1:0][23:0] a0 = '0, a1 = '0;
  logic [1:0][31:0] rd0, rd1;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[2][$];
  int   grants[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   nrsp[2], last_acc[2], last_rsp[2], hi_run[2], last_gap[2], nrise[2], lrise[2];
  logic [31:0] shw[2], cmdw[2];
  logic [1:0] pclk = '0, pmosi = '0;

  always #5 clock = ~clock;

  spi_flash_arbiter #(.CLK_DIV(2)) dut2 (
    .clock(clock), .resetb(resetb),
    .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_ready(r0[0]),
    .rsp0_valid(rv0[0]), .rsp0_data(rd0[0]),
    .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_ready(r1[0]),
    .rsp1_valid(rv1[0]), .rsp1_data(rd1[0]),
    .spi_csb(csb[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
    .busy(busy[0])
  );

  spi_flash_arbiter #(.CLK_DIV(1)) dut1 (
    .clock(clock), .resetb(resetb),
    .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_ready(r0[1]),
    .rsp0_valid(rv0[1]), .rsp0_data(rd0[1]),
    .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_ready(r1[1]),
    .rsp1_valid(rv1[1]), .rsp1_data(rd1[1]),
    .spi_csb(csb[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
    .busy(busy[1])
  );

  function automatic int divk(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Flash contents: 0x000100..0x000103 hold 11 22 33 44.
  function automatic logic [7:0] fbyte(logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] + 8'd1;
    return 8'(t * 8'h11) ^ a[23:16];
  endfunction

  function automatic logic [31:0] exp_word(logic [23:0] addr);
    logic [23:0] wa;
    wa = {addr[23:2], 2'b00};
    return {fbyte(wa + 24'd3), fbyte(wa + 24'd2), fbyte(wa + 24'd1), fbyte(wa)};
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Scoreboard monitor and SPI flash model, sampled on the falling edge.
  initial begin : mon
    exp_t e;
    logic [7:0] b;
    int j;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (r0[k] && r1[k]) begin
          errors++;
          $display("FAIL ready_exclusive inst%0d r0=%b r1=%b want not both", k, r0[k], r1[k]);
        end
        if (v0[k] && r0[k]) begin
          sb[k].push_back('{1'b0, exp_word(a0[k]), cyc});
          if (k == 0) grants.push_back(0);
          last_acc[k] = cyc;
        end
        if (v1[k] && r1[k]) begin
          sb[k].push_back('{1'b1, exp_word(a1[k]), cyc});
          if (k == 0) grants.push_back(1);
          last_acc[k] = cyc;
        end
        if (rv0[k] || rv1[k]) begin
          checks++;
          if (sb[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp inst%0d rv0=%b rv1=%b want none", k, rv0[k], rv1[k]);
          end else begin
            e = sb[k].pop_front();
            if ((rv0[k] && rv1[k]) || rv1[k] !== e.id ||
                (rv1[k] ? rd1[k] : rd0[k]) !== e.data ||
                (cyc - e.acc) != 130 * divk(k) + 1) begin
              errors++;
              $display("FAIL rsp inst%0d id=%b data=%h lat=%0d want id=%b data=%h lat=%0d",
                       k, rv1[k], rv1[k] ? rd1[k] : rd0[k], cyc - e.acc,
                       e.id, e.data, 130 * divk(k) + 1);
            end
          end
          nrsp[k]++;
          last_rsp[k] = cyc;
        end
        if (csb[k]) begin
          hi_run[k]++;
        end else begin
          if (hi_run[k] > 0) last_gap[k] = hi_run[k];
          hi_run[k] = 0;
        end
        if (sclk[k]) begin
          checks++;
          if (mosi[k] !== pmosi[k]) begin
            errors++;
            $display("FAIL mosi_stable inst%0d mosi=%b want %b while spi_clk high", k, mosi[k], pmosi[k]);
          end
        end
        if (csb[k]) begin
          nrise[k] = 0;
          miso[k] = 1'b0;
        end else if (sclk[k] && !pclk[k]) begin
          shw[k] = {shw[k][30:0], mosi[k]};
          nrise[k]++;
          if (nrise[k] > 1) begin
            checks++;
            if (cyc - lrise[k] != 2 * divk(k)) begin
              errors++;
              $display("FAIL sclk_period inst%0d got=%0d want=%0d", k, cyc - lrise[k], 2 * divk(k));
            end
          end
          lrise[k] = cyc;
          if (nrise[k] == 32) cmdw[k] = shw[k];
        end else if (!sclk[k] && pclk[k] && nrise[k] >= 32 && nrise[k] < 64) begin
          j = nrise[k] - 32;
          b = fbyte(cmdw[k][23:0] + 24'(j / 8));
          miso[k] = b[7 - (j % 8)];
        end
        pclk[k] = sclk[k];
        pmosi[k] = mosi[k];
      end
    end
  end

  task automatic test_reset();
    v0 = 2'b11; v1 = 2'b11;
    a0[0] = 24'h120040; a1[0] = 24'h340081;
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (csb[k] !== 1'b1 || sclk[k] !== 1'b0 || mosi[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_pins inst%0d csb=%b clk=%b mosi=%b want 1 0 0", k, csb[k], sclk[k], mosi[k]);
      end
      checks++;
      if ({r0[k], r1[k], rv0[k], rv1[k], busy[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_handshake inst%0d got=%b want=00000", k, {r0[k], r1[k], rv0[k], rv1[k], busy[k]});
      end
      checks++;
      if (rd0[k] !== 32'h0 || rd1[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data inst%0d rd0=%h rd1=%h want 0", k, rd0[k], rd1[k]);
      end
    end
    @(posedge clock); #1;
    v0[1] = 1'b0; v1[1] = 1'b0;
  endtask

  task automatic test_contention();
    logic ok = 1'b0;
    grants.delete();
    nrsp[0] = 0;
    @(posedge clock); #1;
    resetb = 1'b1;
    for (int i = 0; i < 1300 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[0] >= 4) ok = 1'b1;
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL contention_timeout rsps=%0d want 4", nrsp[0]);
    end
    checks++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL contention_count grants=%0d want 4", grants.size());
    end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        errors++;
        $display("FAIL contention_order idx%0d got=%0d want=%0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_single_read();
    logic ok = 1'b0;
    int base = nrsp[0];
    @(posedge clock); #1;
    a0[0] = 24'h000100; v0[0] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); #1;
      if (r0[0]) ok = 1'b1;
    end
    @(posedge clock); #1;
    v0[0] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_grant_timeout ready=%b want 1", r0[0]); end
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[0] > base) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL single_rsp_timeout rsps=%0d want %0d", nrsp[0], base + 1); end
    checks++;
    if (rd0[0] !== 32'h44332211) begin errors++; $display("FAIL single_data got=%h want=44332211", rd0[0]); end
    checks++;
    if (cmdw[0] !== 32'h03000100) begin errors++; $display("FAIL single_mosi got=%h want=03000100", cmdw[0]); end
    checks++;
    if (last_rsp[0] - last_acc[0] != 261) begin
      errors++; $display("FAIL single_latency got=%0d want=261", last_rsp[0] - last_acc[0]);
    end
  endtask

  task automatic test_alignment();
    logic ok = 1'b0;
    int base = nrsp[0];
    @(posedge clock); #1;
    a1[0] = 24'h000103; v1[0] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); #1;
      if (r1[0]) ok = 1'b1;
    end
    @(posedge clock); #1;
    v1[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[0] > base) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL align_timeout rsps=%0d want %0d", nrsp[0], base + 1); end
    checks++;
    if (cmdw[0] !== 32'h03000100) begin errors++; $display("FAIL align_mosi got=%h want=03000100", cmdw[0]); end
    checks++;
    if (rd1[0] !== 32'h44332211) begin errors++; $display("FAIL align_data1 got=%h want=44332211", rd1[0]); end
    checks++;
    if (rd0[0] !== 32'h44332211) begin errors++; $display("FAIL align_data0_held got=%h want=44332211", rd0[0]); end
  endtask

  task automatic test_back_to_back();
    logic ok = 1'b0;
    int base = nrsp[0];
    int r1c = 0;
    @(posedge clock); #1;
    a0[0] = 24'h0A0204; v0[0] = 1'b1;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[0] == base + 1 && r1c == 0) r1c = last_rsp[0];
      if (nrsp[0] >= base + 2) ok = 1'b1;
    end
    v0[0] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout rsps=%0d want %0d", nrsp[0], base + 2); end
    checks++;
    if (last_acc[0] - r1c != 1) begin
      errors++; $display("FAIL b2b_accept_gap got=%0d want=1", last_acc[0] - r1c);
    end
    checks++;
    if (last_gap[0] < 3) begin errors++; $display("FAIL b2b_csb_gap got=%0d want>=3", last_gap[0]); end
  endtask

  task automatic test_reset_mid();
    logic ok = 1'b0;
    int base;
    @(posedge clock); #1;
    a0[0] = 24'h5A0310; v0[0] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); #1;
      if (r0[0]) ok = 1'b1;
    end
    @(posedge clock); #1;
    v0[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrise[0] == 18) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_reach got=%0d want 18 rises", nrise[0]); end
    resetb = 1'b0;
    #1;
    sb[0].delete();
    base = nrsp[0];
    checks++;
    if (csb[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async csb=%b clk=%b busy=%b want 1 0 0", csb[0], sclk[0], busy[0]);
    end
    checks++;
    if (rd0[0] !== 32'h0) begin errors++; $display("FAIL midrst_data got=%h want=0", rd0[0]); end
    repeat (4) @(posedge clock);
    #1;
    resetb = 1'b1;
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (nrsp[0] != base || busy[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_no_rsp rsps=%0d busy=%b want %0d 0", nrsp[0], busy[0], base);
    end
    @(posedge clock); #1;
    a0[0] = 24'h7F00FC; v0[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); #1;
      if (r0[0]) ok = 1'b1;
    end
    @(posedge clock); #1;
    v0[0] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[0] > base) ok = 1'b1;
    end
    checks++;
    if (!ok || nrsp[0] != base + 1) begin
      errors++; $display("FAIL midrst_resume rsps=%0d want %0d", nrsp[0], base + 1);
    end
    checks++;
    if (cmdw[0] !== 32'h037F00FC) begin errors++; $display("FAIL midrst_mosi got=%h want=037f00fc", cmdw[0]); end
    checks++;
    if (rd0[0] !== 32'h7F90A1B2) begin errors++; $display("FAIL midrst_data_after got=%h want=7f90a1b2", rd0[0]); end
  endtask

  task automatic test_clkdiv1();
    logic ok = 1'b0;
    int base = nrsp[1];
    @(posedge clock); #1;
    a0[1] = 24'h000100; v0[1] = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock); #1;
      if (r0[1]) ok = 1'b1;
    end
    @(posedge clock); #1;
    v0[1] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 250 && !ok; i++) begin
      @(negedge clock); #1;
      if (nrsp[1] > base) ok = 1'b1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL div1_timeout rsps=%0d want %0d", nrsp[1], base + 1); end
    checks++;
    if (last_rsp[1] - last_acc[1] != 131) begin
      errors++; $display("FAIL div1_latency got=%0d want=131", last_rsp[1] - last_acc[1]);
    end
    checks++;
    if (rd0[1] !== 32'h44332211) begin errors++; $display("FAIL div1_data got=%h want=44332211", rd0[1]); end
    checks++;
    if (cmdw[1] !== 32'h03000100) begin errors++; $display("FAIL div1_mosi got=%h want=03000100", cmdw[1]); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_alignment();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_arbiter.md
SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: SPI clock half-period in clock cycles, legal range 1..15.
REQ-002 SHALL have port clock, input, 1: the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port resetb, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid (input, 1), req0_addr (input, 24) and req0_ready (output, 1): requester 0 (CPU fetch) read request.
REQ-005 SHALL have ports rsp0_valid (output, 1) and rsp0_data (output, 32): requester 0 response.
REQ-006 SHALL have ports req1_valid, req1_addr, req1_ready, rsp1_valid and rsp1_data, with the same directions and widths: requester 1 (debugger).
REQ-007 SHALL have ports spi_csb (output, 1), spi_clk (output, 1), spi_mosi (output, 1) and spi_miso (input, 1): flash pins.
REQ-008 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-009 SHALL implement the states IDLE, CS_SETUP, SHIFT, CS_HOLD and RESP.
REQ-010 In IDLE, with at least one reqN_valid high, SHALL grant one requester, pulse its reqN_ready for exactly one cycle, capture its address and go to CS_SETUP.
REQ-011 SHALL arbitrate round-robin: when both requesters are valid, grant the one not granted last; after reset, requester 0 has priority.
REQ-012 reqN_ready SHALL be high only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-013 A request SHALL be accepted only in a cycle where valid and ready are both high; requests arriving while busy wait and are not dropped.
REQ-014 SHALL drive spi_csb low from the cycle after acceptance; CS_SETUP SHALL last CLK_DIV cycles with spi_clk low.
REQ-015 SHIFT SHALL transfer 64 bits in SPI mode 0: spi_clk idles low and each bit is CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-016 spi_mosi SHALL change only while spi_clk is low.
REQ-017 spi_miso SHALL be sampled on the clock cycle in which spi_clk rises.
REQ-018 The bit order SHALL be: command 0x03, MSB first; then the 24-bit address, MSB first, with addr[1:0] forced to 00 on the wire; then 32 data bits.
REQ-019 SHALL drive spi_mosi to 0 during the data phase.
REQ-020 Data SHALL be assembled little-endian: the first byte received goes to rsp_data[7:0], the last to rsp_data[31:24], and each byte is MSB first.
REQ-021 CS_HOLD SHALL drive spi_csb high and spi_clk low for CLK_DIV cycles.
REQ-022 RESP SHALL assert rspN_valid of the granted requester for exactly one cycle, then return to IDLE.
REQ-023 rspN_data SHALL hold its value until that requester's next response.
REQ-024 rspN_valid SHALL be high exactly 130*CLK_DIV+1 cycles after the acceptance cycle (261 for CLK_DIV=2).
REQ-025 A new request SHALL be acceptable in the cycle after RESP, so back-to-back transactions keep spi_csb high for at least CLK_DIV+1 cycles between them.
REQ-026 The bit counter SHALL be 6 bits wide, and the phase counter SHALL count 0..CLK_DIV-1 and wrap.
REQ-027 Requester inputs SHALL be ignored outside IDLE, and captured address and grant SHALL NOT change mid-transaction.

Reset
REQ-028 While resetb is low, outputs SHALL be: spi_csb=1, spi_clk=0, spi_mosi=0, all ready/valid/busy=0, rsp data=0, state=IDLE, last-grant=1 so that requester 0 wins first.
REQ-029 Reset asserted mid-transaction SHALL immediately raise spi_csb and produce no response.
REQ-030 After reset release, the first transaction SHALL start with a fresh command and SHALL NOT resume the interrupted one.

Verification
REQ-031 Single read: req0 addr 0x000100, flash bytes 11 22 33 44 -> MOSI bits 0x03,0x00,0x01,0x00; rsp0_data=0x44332211 at cycle 261.
REQ-032 Alignment: req1 addr 0x000103 -> wire address 0x000100; only rsp1_valid pulses, rsp0 is untouched.
REQ-033 Contention: both requesters valid continuously from reset -> grants 0,1,0,1 and four responses in that order.
REQ-034 Reset mid-operation: resetb pulled low during the 10th address bit -> spi_csb high asynchronously, no rsp pulse; after release, req0 completes normally.
REQ-035 CLK_DIV=1 -> spi_clk period is 2 cycles, latency is 131 cycles, and the MOSI stability rule is met.
